// File: rtl/vga_cap_pkg.sv
// Shared types and constants for the VGA scanline capture peripheral.
package vga_cap_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWaitVsync,
      StCountLines,
      StWaitPorch,
      StCapture,
      StDone
   } state_t;

   localparam logic [5:0] REG_CTRL   = 6'h30;
   localparam logic [5:0] REG_PORCH  = 6'h34;
   localparam logic [5:0] REG_STATUS = 6'h3C;

   localparam int unsigned STAT_BUSY     = 0;
   localparam int unsigned STAT_DONE     = 1;
   localparam int unsigned STAT_SHORT    = 2;
   localparam int unsigned STAT_NO_LINE  = 3;
   localparam int unsigned STAT_LINE_LSB = 4;

   localparam int unsigned UI_PIXEL = 0;
   localparam int unsigned UI_HSYNC = 1;
   localparam int unsigned UI_VSYNC = 2;

   function automatic logic bus_active(input logic [1:0] n);
      return n != 2'b11;
   endfunction

   function automatic logic bus_wide(input logic [1:0] n);
      return (n == 2'b01) || (n == 2'b10);
   endfunction

endpackage

// File: rtl/vga_cap_sync_edge.sv
// Registers pixel/hsync/vsync once more, normalizes syncs to active-high and
// produces single-cycle assert/deassert pulses aligned with the registered pixel.
module vga_cap_sync_edge
   import vga_cap_pkg::*;
#(
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] raw,
   output logic       pixel,
   output logic       hsync_assert,
   output logic       hsync_deassert,
   output logic       vsync_assert
);

   localparam logic [2:0] POLARITY = {SYNC_ACTIVE_LOW, SYNC_ACTIVE_LOW, 1'b0};

   logic [2:0] raw_q;
   logic [2:0] norm;
   logic       hsync_prev;
   logic       vsync_prev;

   assign norm = raw_q ^ POLARITY;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // Out of reset the syncs look idle, so no spurious edge is seen.
         raw_q      <= POLARITY;
         hsync_prev <= 1'b0;
         vsync_prev <= 1'b0;
      end else begin
         raw_q      <= raw;
         hsync_prev <= norm[UI_HSYNC];
         vsync_prev <= norm[UI_VSYNC];
      end
   end

   assign pixel          = norm[UI_PIXEL];
   assign hsync_assert   = norm[UI_HSYNC] & ~hsync_prev;
   assign hsync_deassert = ~norm[UI_HSYNC] & hsync_prev;
   assign vsync_assert   = norm[UI_VSYNC] & ~vsync_prev;

endmodule

// File: rtl/tqvp_rejunity_vga_capture.sv
// TinyQV peripheral capturing one 1bpp VGA scanline into a readable buffer.
// Define VGA_CAP_IRQ_EN to drive user_interrupt from the done flag.
module tqvp_rejunity_vga_capture
   import vga_cap_pkg::*;
#(
   parameter int unsigned PIXEL_COUNT     = 320,
   parameter int unsigned SAMPLE_DIV      = 1,
   parameter bit          SYNC_ACTIVE_LOW = 1'b1,
   parameter logic [7:0]  PORCH_RESET     = 8'd48
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  ui_in,
   output logic [7:0]  uo_out,
   input  logic [5:0]  address,
   input  logic [31:0] data_in,
   input  logic [1:0]  data_write_n,
   input  logic [1:0]  data_read_n,
   output logic [31:0] data_out,
   output logic        data_ready,
   output logic        user_interrupt
);

   localparam int unsigned      IDX_W     = $clog2(PIXEL_COUNT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PIXEL_COUNT - 1);
   localparam logic [7:0]       DIV_LAST  = 8'(SAMPLE_DIV - 1);
   localparam logic [4:0]       NUM_WORDS = 5'(PIXEL_COUNT / 32);

   state_t                   state;
   logic                     busy, done, short_line, no_line;
   logic [9:0]               line_cnt, target;
   logic [7:0]               porch, delay, div_cnt;
   logic [IDX_W-1:0]         idx;
   logic [PIXEL_COUNT-1:0]   buffer;
   logic                     pixel, hs_assert, hs_deassert, vs_assert;
   logic                     wr_ctrl, wr_porch, wr_status;
   logic [31:0]              status;
   logic                     unused_bits;

   vga_cap_sync_edge #(
      .SYNC_ACTIVE_LOW(SYNC_ACTIVE_LOW)
   ) u_sync_edge (
      .clk           (clk),
      .rst           (rst),
      .raw           (ui_in[2:0]),
      .pixel         (pixel),
      .hsync_assert  (hs_assert),
      .hsync_deassert(hs_deassert),
      .vsync_assert  (vs_assert)
   );

   assign wr_ctrl   = (address == REG_CTRL) && bus_wide(data_write_n);
   assign wr_porch  = (address == REG_PORCH) && bus_active(data_write_n);
   assign wr_status = (address == REG_STATUS) && bus_active(data_write_n);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= StIdle;
         busy       <= 1'b0;
         done       <= 1'b0;
         short_line <= 1'b0;
         no_line    <= 1'b0;
         line_cnt   <= '0;
         target     <= '0;
         porch      <= PORCH_RESET;
         delay      <= '0;
         div_cnt    <= '0;
         idx        <= '0;
         buffer     <= '0;
      end else begin
         if (wr_porch) porch <= data_in[7:0];
         if (wr_status) begin
            done       <= 1'b0;
            short_line <= 1'b0;
            no_line    <= 1'b0;
         end
         if (wr_ctrl) begin
            // Arming (or re-arming) always restarts from the next frame.
            target     <= data_in[9:0];
            done       <= 1'b0;
            short_line <= 1'b0;
            no_line    <= 1'b0;
            buffer     <= '0;
            state      <= StWaitVsync;
            busy       <= 1'b1;
         end else begin
            case (state)
               StIdle: ;
               StWaitVsync: begin
                  if (vs_assert) begin
                     line_cnt <= '0;
                     state    <= StCountLines;
                  end
               end
               StCountLines: begin
                  if (vs_assert) begin
                     no_line <= 1'b1;
                     done    <= 1'b1;
                     state   <= StDone;
                  end else if (hs_deassert) begin
                     if (line_cnt == target) begin
                        idx     <= '0;
                        div_cnt <= '0;
                        delay   <= porch;
                        // porch pixels are skipped after the pixel seen with the deassert
                        state   <= (porch == 8'd0) ? StCapture : StWaitPorch;
                     end else if (line_cnt != 10'h3FF) begin
                        line_cnt <= line_cnt + 10'd1;
                     end
                  end
               end
               StWaitPorch: begin
                  delay <= delay - 8'd1;
                  if (delay == 8'd1) state <= StCapture;
               end
               StCapture: begin
                  if (hs_assert) begin
                     short_line <= 1'b1;
                     done       <= 1'b1;
                     state      <= StDone;
                  end else begin
                     div_cnt <= (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
                     if (div_cnt == 8'd0) begin
                        buffer[idx] <= pixel;
                        idx         <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                           done  <= 1'b1;
                           state <= StDone;
                        end
                     end
                  end
               end
               StDone: begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
               default: begin
                  state <= StIdle;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      status                        = '0;
      status[STAT_BUSY]             = busy;
      status[STAT_DONE]             = done;
      status[STAT_SHORT]            = short_line;
      status[STAT_NO_LINE]          = no_line;
      status[STAT_LINE_LSB +: 10]   = line_cnt;
   end

   always_comb begin
      data_out = '0;
      if ({1'b0, address[5:2]} < NUM_WORDS) begin
         data_out = buffer[{address[5:2], 5'd0} +: 32];
      end else if (address == REG_PORCH) begin
         data_out = {24'd0, porch};
      end else if (address == REG_STATUS) begin
         data_out = status;
      end
   end

   assign uo_out      = {6'b0, done, busy};
   assign data_ready  = 1'b1;
   assign unused_bits = ^{ui_in[7:3], data_in[31:10], data_read_n};

`ifdef VGA_CAP_IRQ_EN
   assign user_interrupt = done;
`else
   assign user_interrupt = 1'b0;
`endif

endmodule
